// File: rtl/util_pkg.sv
// Shared helpers for the util_* blocks: index-width derivation, arbiter FSM
// encoding and a saturating adder.
package util_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Returns a + b clamped to max_v; the 33-bit sum keeps the carry visible.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, max_v}) begin
            return max_v;
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/util_rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the slot after
// `last` is bit 0, priority-encode, then rotate the index back.
module util_rr_pick
    import util_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_vld
);

    logic [NUM_CH-1:0] rot;
    int                base;
    int                offs;

    always_comb begin
        rot     = '0;
        base    = int'(last) + 1;
        offs    = 0;
        gnt_vld = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            rot[j] = req[(base + j) % NUM_CH];
        end
        // Scan downwards so the lowest rotated position wins.
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (rot[j]) begin
                gnt_vld = 1'b1;
                offs    = j;
            end
        end
        gnt_idx = CH_W'((base + offs) % NUM_CH);
    end

endmodule

// File: rtl/util_edge_event_arbiter.sv
// Latches edge pulses from NUM_CH channels as pending events and hands them to a
// single consumer one at a time in round-robin order, counting events lost.
module util_edge_event_arbiter
    import util_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 8,
    localparam int CH_W   = clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] evt_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CH_W-1:0]   m_ch,
    output logic              m_ovf,
    output logic [NUM_CH-1:0] pending,
    output logic [CNT_W-1:0]  ovf_cnt,
    input  logic              ovf_clr,
    output logic              busy
);

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF >> (32 - CNT_W);

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] lost_q, lost_d;
    logic [CH_W-1:0]   m_ch_q, m_ch_d;
    logic              m_ovf_q, m_ovf_d;
    logic [CH_W-1:0]   rr_last_q, rr_last_d;
    logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

    logic [NUM_CH-1:0] req;
    logic [CH_W-1:0]   sel;
    logic              sel_vld;
    logic              load;
    logic              set_i;
    logic              clr_i;
    logic              loss_i;
    logic [31:0]       loss_cnt;
    logic [31:0]       cnt_base;
    logic [31:0]       cnt_sum;

    // Disabled channels are masked so a flag being flushed is never granted.
    assign req = pending_q & ch_en;

    util_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req     (req),
        .last    (rr_last_q),
        .gnt_idx (sel),
        .gnt_vld (sel_vld)
    );

    // Handshake: a transfer happens on a clock edge where m_valid & m_ready;
    // m_ch/m_ovf hold while m_valid is high and m_ready is low.
    always_comb begin
        state_d   = state_q;
        m_ch_d    = m_ch_q;
        m_ovf_d   = m_ovf_q;
        rr_last_d = rr_last_q;
        pending_d = pending_q;
        lost_d    = lost_q;
        load      = 1'b0;
        set_i     = 1'b0;
        clr_i     = 1'b0;
        loss_i    = 1'b0;
        loss_cnt  = '0;
        cnt_base  = '0;
        cnt_sum   = '0;

        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    load    = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (m_ready) begin
                    if (sel_vld) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            m_ch_d    = sel;
            m_ovf_d   = lost_q[sel];
            rr_last_d = sel;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            set_i  = evt_in[i] & ch_en[i];
            clr_i  = load && (sel == CH_W'(i));
            loss_i = set_i & pending_q[i] & ~clr_i;
            if (!ch_en[i]) begin
                pending_d[i] = 1'b0;
                lost_d[i]    = 1'b0;
            end else begin
                pending_d[i] = set_i | (pending_q[i] & ~clr_i);
                lost_d[i]    = loss_i | (lost_q[i] & ~clr_i);
            end
            loss_cnt = loss_cnt + 32'(loss_i);
        end

        // A clear drops the old total but keeps losses from this same cycle.
        cnt_base  = ovf_clr ? 32'd0 : 32'(ovf_cnt_q);
        cnt_sum   = sat_add(cnt_base, loss_cnt, CNT_MAX);
        ovf_cnt_d = cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            lost_q    <= '0;
            m_ch_q    <= '0;
            m_ovf_q   <= 1'b0;
            rr_last_q <= CH_W'(NUM_CH - 1);
            ovf_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            lost_q    <= lost_d;
            m_ch_q    <= m_ch_d;
            m_ovf_q   <= m_ovf_d;
            rr_last_q <= rr_last_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign m_valid = (state_q == ST_OFFER);
    assign m_ch    = m_ch_q;
    assign m_ovf   = m_ovf_q;
    assign pending = pending_q;
    assign ovf_cnt = ovf_cnt_q;
    assign busy    = m_valid | (|pending_q);

endmodule
